// File: rtl/ts_cut_head_n.sv
// ---------------------------------------------------------------------------
// ts_cut_head_n
//
// Purpose:
//   Drops the first N words of every input burst and forwards the rest with
//   one cycle of latency. A burst is a contiguous run of ts_din_en=1 cycles.
//   N is taken from cut_head on the first word of the burst and then held for
//   the whole burst, so cut_head may change mid-burst without effect.
//   The first forwarded word of each burst is flagged with ts_dout_sop.
//   With N=1 this behaves as the classic single-word head cut.
//
// Parameters:
//   DW           data word width
//   CW           width of the cut_head count
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   ts_din_en    input word valid
//   ts_din       input data word
//   cut_head     words to drop at the head of each burst
//   ts_dout      registered copy of ts_din (qualified only by ts_dout_en)
//   ts_dout_en   output word valid
//   ts_dout_sop  first kept word of a burst
//
// Optional feature (macro TS_CUT_HEAD_STAT_EN):
//   burst_cnt    number of bursts started, saturating at 0xFFFFFFFF
//   drop_cnt     number of words dropped, saturating at 0xFFFFFFFF
// ---------------------------------------------------------------------------
module ts_cut_head_n #(
  parameter int DW = 32,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ts_din_en,
  input  logic [DW-1:0] ts_din,
  input  logic [CW-1:0] cut_head,
  output logic [DW-1:0] ts_dout,
  output logic          ts_dout_en,
  output logic          ts_dout_sop
`ifdef TS_CUT_HEAD_STAT_EN
  ,
  output logic [31:0]   burst_cnt,
  output logic [31:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CUT  = 2'd1,
    PASS = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_prev_en;

  logic          w_start;
  logic          w_emit;
  logic          w_sop;
  logic          w_drop;

  logic [DW-1:0] r_dout;
  logic          r_dout_en;
  logic          r_dout_sop;

  // A burst starts on a valid word whose previous cycle was not valid.
  // r_prev_en is cleared by reset, so a burst that is still running when
  // reset releases is seen as a fresh burst.
  assign w_start = ts_din_en & ~r_prev_en;

  // State, remaining-drop counter and previous-enable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_prev_en <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_prev_en <= ts_din_en;
    end
  end

  // r_cnt holds how many more words must be dropped after the current one.
  // It is loaded with N-1 on the burst start word (that word is itself
  // dropped) and only decremented while non-zero, so it never wraps.
  // When it reads zero in CUT, the current word is the first one kept.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_sop       = 1'b0;
    w_drop      = 1'b0;

    if (!ts_din_en) begin
      w_state_nxt = IDLE;
    end else if (w_start) begin
      if (cut_head == '0) begin
        w_state_nxt = PASS;
        w_emit      = 1'b1;
        w_sop       = 1'b1;
      end else begin
        w_state_nxt = CUT;
        w_cnt_nxt   = cut_head - CW'(1);
        w_drop      = 1'b1;
      end
    end else begin
      case (r_state)
        CUT: begin
          if (r_cnt == '0) begin
            w_state_nxt = PASS;
            w_emit      = 1'b1;
            w_sop       = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
            w_drop      = 1'b1;
          end
        end
        PASS: begin
          w_emit = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output stage: data is always registered; only the strobes depend on
  // the FSM decision for the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout     <= '0;
      r_dout_en  <= 1'b0;
      r_dout_sop <= 1'b0;
    end else begin
      r_dout     <= ts_din;
      r_dout_en  <= w_emit;
      r_dout_sop <= w_sop;
    end
  end

  assign ts_dout     = r_dout;
  assign ts_dout_en  = r_dout_en;
  assign ts_dout_sop = r_dout_sop;

`ifdef TS_CUT_HEAD_STAT_EN
  logic [31:0] r_burst_cnt;
  logic [31:0] r_drop_cnt;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_start && (r_burst_cnt != 32'hFFFF_FFFF)) begin
        r_burst_cnt <= r_burst_cnt + 32'd1;
      end
      if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign burst_cnt = r_burst_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_ts_cut_head_n.sv
// ---------------------------------------------------------------------------
// tb_ts_cut_head_n
//
// Directed testbench for ts_cut_head_n. Each call of applyStimulus drives one
// cycle of inputs and checks the outputs that those inputs produce one clock
// later against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ts_cut_head_n;

  logic        clk;
  logic        rst;
  logic        tsDinEn;
  logic [31:0] tsDin;
  logic [3:0]  cutHead;
  logic [31:0] tsDout;
  logic        tsDoutEn;
  logic        tsDoutSop;
`ifdef TS_CUT_HEAD_STAT_EN
  logic [31:0] burstCnt;
  logic [31:0] dropCnt;
`endif

  int totalCount = 0;
  int badCount   = 0;

  ts_cut_head_n #(
    .DW(32),
    .CW(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ts_din_en  (tsDinEn),
    .ts_din     (tsDin),
    .cut_head   (cutHead),
    .ts_dout    (tsDout),
    .ts_dout_en (tsDoutEn),
    .ts_dout_sop(tsDoutSop)
`ifdef TS_CUT_HEAD_STAT_EN
    ,
    .burst_cnt  (burstCnt),
    .drop_cnt   (dropCnt)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge, then checks the
  // registered outputs just after the following rising edge.
  task automatic applyStimulus(input string tag, input logic rstIn,
                               input logic en, input logic [31:0] din,
                               input logic [3:0] cut, input logic expEn,
                               input logic expSop, input logic [31:0] expDout);
    @(negedge clk);
    rst     = rstIn;
    tsDinEn = en;
    tsDin   = din;
    cutHead = cut;
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s en", tag),   32'(tsDoutEn),  32'(expEn));
    checkOutput($sformatf("%s sop", tag),  32'(tsDoutSop), 32'(expSop));
    checkOutput($sformatf("%s dout", tag), tsDout,         expDout);
  endtask

  // Directed scenario list.
  initial begin
    rst     = 1'b0;
    tsDinEn = 1'b1;
    tsDin   = 32'hFFFF_FFFF;
    cutHead = 4'd0;

    // Reset state, with active-looking inputs that must be ignored.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst en",   32'(tsDoutEn),  32'd0);
    checkOutput("rst sop",  32'(tsDoutSop), 32'd0);
    checkOutput("rst dout", tsDout,         32'd0);

    applyStimulus("idle0", 1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);

    // cut 1, burst of 5: D1..D4 out, sop with D1.
    for (int i = 0; i < 5; i++)
      applyStimulus($sformatf("cut1[%0d]", i), 1'b1, 1'b1, 32'h10 + i, 4'd1,
                    (i >= 1), (i == 1), 32'h10 + i);
    applyStimulus("cut1gap", 1'b1, 1'b0, 32'hDEAD, 4'd1, 1'b0, 1'b0, 32'hDEAD);

    // cut 3, burst of 3 is entirely dropped.
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("cut3a[%0d]", i), 1'b1, 1'b1, 32'h20 + i, 4'd3,
                    1'b0, 1'b0, 32'h20 + i);
    applyStimulus("cut3gap", 1'b1, 1'b0, 32'hBEEF, 4'd3, 1'b0, 1'b0, 32'hBEEF);

    // cut 3, burst of 6: E3..E5 out, sop with E3.
    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("cut3b[%0d]", i), 1'b1, 1'b1, 32'h30 + i, 4'd3,
                    (i >= 3), (i == 3), 32'h30 + i);
    applyStimulus("cut3bgap", 1'b1, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 32'h0);

    // cut 0: everything passes, sop on the first word.
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("cut0[%0d]", i), 1'b1, 1'b1, 32'hA5A5_0000 + i,
                    4'd0, 1'b1, (i == 0), 32'hA5A5_0000 + i);
    applyStimulus("cut0gap", 1'b1, 1'b0, 32'h1234, 4'd2, 1'b0, 1'b0, 32'h1234);

    // cut 2 at start, cut_head moved to 7 mid-burst: still 6 of 8 out.
    for (int i = 0; i < 8; i++)
      applyStimulus($sformatf("chg[%0d]", i), 1'b1, 1'b1, 32'h40 + i,
                    (i >= 2) ? 4'd7 : 4'd2, (i >= 2), (i == 2), 32'h40 + i);
    applyStimulus("chggap", 1'b1, 1'b0, 32'h0, 4'd15, 1'b0, 1'b0, 32'h0);

    // Largest cut (15) on a 17-word burst: last two words kept.
    for (int i = 0; i < 17; i++)
      applyStimulus($sformatf("cut15[%0d]", i), 1'b1, 1'b1, 32'h100 + i, 4'd15,
                    (i >= 15), (i == 15), 32'h100 + i);
    applyStimulus("cut15gap", 1'b1, 1'b0, 32'h0, 4'd2, 1'b0, 1'b0, 32'h0);

    // Reset for 2 cycles during PASS of a 10-word burst with enable held
    // high: outputs zero during reset, then the remainder is a new burst.
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 5)
        applyStimulus($sformatf("rstmid[%0d]", i), 1'b0, 1'b1, 32'h50 + i, 4'd2,
                      1'b0, 1'b0, 32'h0);
      else
        applyStimulus($sformatf("rstmid[%0d]", i), 1'b1, 1'b1, 32'h50 + i, 4'd2,
                      (i == 2 || i == 3 || i >= 8), (i == 2 || i == 8),
                      32'h50 + i);
    end
    applyStimulus("rstmidgap", 1'b1, 1'b0, 32'h0, 4'd1, 1'b0, 1'b0, 32'h0);

`ifdef TS_CUT_HEAD_STAT_EN
    // Clear the counters, then three bursts of 4 with cut 1.
    applyStimulus("statrst", 1'b0, 1'b0, 32'h0, 4'd1, 1'b0, 1'b0, 32'h0);
    checkOutput("statrst burst", burstCnt, 32'd0);
    checkOutput("statrst drop",  dropCnt,  32'd0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++)
        applyStimulus($sformatf("stat%0d[%0d]", b, i), 1'b1, 1'b1,
                      32'h60 + 4 * b + i, 4'd1, (i >= 1), (i == 1),
                      32'h60 + 4 * b + i);
      applyStimulus($sformatf("stat%0dgap", b), 1'b1, 1'b0, 32'h0, 4'd1,
                    1'b0, 1'b0, 32'h0);
    end
    checkOutput("stat burst", burstCnt, 32'd3);
    checkOutput("stat drop",  dropCnt,  32'd3);
`endif

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule

// File: doc/ts_cut_head_n.md
TS_CUT_HEAD_N -- requirements
Module: ts_cut_head_n

Interface
REQ-001 Parameter DW, default 32: data word width in bits.
REQ-002 Parameter CW, default 4: width of the head-cut count input.
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  asynchronous reset, active-low (logic held in reset while rst=0).
REQ-005 Port ts_din_en  input  1  word valid; a contiguous high run is one burst.
REQ-006 Port ts_din  input  DW  input data word.
REQ-007 Port cut_head  input  CW  number of leading words to drop per burst; sampled at burst start only.
REQ-008 Port ts_dout  output  DW  registered output word.
REQ-009 Port ts_dout_en  output  1  output word valid.
REQ-010 Port ts_dout_sop  output  1  high with the first kept word of each burst.

Function
REQ-011 Burst start SHALL be the first cycle with ts_din_en=1 following a cycle with ts_din_en=0, or the first ts_din_en=1 cycle after reset release.
REQ-012 FSM states SHALL be IDLE, CUT and PASS.
REQ-013 IDLE, burst start, cut_head=0 -> PASS; the start word SHALL be emitted with ts_dout_sop=1.
REQ-014 IDLE, burst start, cut_head=N>0 -> CUT; the start word SHALL be dropped, and N-1 further words SHALL be dropped before PASS.
REQ-015 CUT SHALL count dropped words in a CW-bit counter loaded at burst start; the counter SHALL NOT wrap. The first word after N drops SHALL enter PASS and assert ts_dout_sop=1.
REQ-016 In PASS, every ts_din_en=1 word SHALL be emitted.
REQ-017 ts_din_en=0 in any state SHALL return the FSM to IDLE next cycle; a burst shorter than or equal to N SHALL produce no output and no sop.
REQ-018 Latency ts_din -> ts_dout SHALL be exactly 1 cycle; ts_dout_en and ts_dout_sop SHALL align with ts_dout.
REQ-019 ts_dout SHALL equal the previous-cycle ts_din regardless of valid; only ts_dout_en qualifies it.
REQ-020 A change of cut_head mid-burst SHALL NOT affect the current burst.
REQ-021 N=1 SHALL reproduce legacy single-word head cut exactly.

Reset
REQ-022 While rst=0: FSM=IDLE, counter=0, ts_dout=0, ts_dout_en=0, ts_dout_sop=0, previous-enable register=0.
REQ-023 Reset asserted mid-burst SHALL discard the burst; a burst in progress at reset release SHALL be treated as a new burst (REQ-011).

Configuration
REQ-024 Macro TS_CUT_HEAD_STAT_EN, when defined, SHALL add outputs burst_cnt[31:0] (bursts started) and drop_cnt[31:0] (words dropped), both reset to 0 and saturating at 0xFFFFFFFF.
REQ-025 Without TS_CUT_HEAD_STAT_EN, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-026 cut_head=1, burst of 5 words D0..D4 -> D1..D4 on 4 consecutive cycles starting 1 cycle after D1 in, sop with D1.
REQ-027 cut_head=3, burst of 3 words then 1 idle cycle, then burst of 6 words E0..E5 -> first burst no output; second burst E3..E5, sop with E3.
REQ-028 cut_head=0, burst 0xA5A5_0000..0xA5A5_0003 -> all 4 words out, sop with 0xA5A5_0000, latency 1.
REQ-029 cut_head=2 at start, change to 7 on cycle 2 of an 8-word burst -> 6 words out (cut of 2 applied).
REQ-030 rst=0 for 2 cycles during PASS of a 10-word burst, ts_din_en kept high, cut_head=2 -> outputs 0 during reset; after release first 2 words dropped, sop on third.
REQ-031 With TS_CUT_HEAD_STAT_EN, 3 bursts of 4 words, cut_head=1 -> burst_cnt=3, drop_cnt=3.
